display_serializer: RTL and testbench
=====================================

Name: display_serializer

Overview:
Parametrised successor to display_decoder. Converts a binary value into up to MAX_DIGITS seven-segment codes. Each code is 7 segments plus a decimal point. Supports decimal or hex radix, leading-zero blanking, per-digit decimal points and overflow indication. The codes are streamed out one bit per next_led strobe to the LED shift-register driver.

Parameters:
DATA_W, 16, width of the input value
MAX_DIGITS, 5, maximum number of digits per frame (1..8)
CNT_W, $clog2(MAX_DIGITS+1), width of digit_count

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a new frame; sampled only in IDLE
data  in  DATA_W  value to display; latched on an accepted start
digit_count  in  CNT_W  digits to emit; latched; values >MAX_DIGITS are clamped to MAX_DIGITS
hex_mode  in  1  latched; 1 = radix 16, 0 = radix 10
blank_lz  in  1  latched; 1 = blank leading zeros
dp_mask  in  MAX_DIGITS  latched; bit i sets the dp of digit i (digit 0 = least significant)
next_led  in  1  single-cycle strobe; advances the serial bit
led_data  out  1  current serial bit
led_valid  out  1  high while led_data carries a frame bit
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the frame is complete
overflow  out  1  sticky per frame: value does not fit in digit_count digits

Behaviour:
- Reset values: led_data=0, led_valid=0, busy=0, done=0, overflow=0. State=IDLE. All counters and buffers are cleared.
- Reset mid-frame: on the next edge the block returns to IDLE with the reset values; the frame is abandoned and no done pulse is issued.
- States: IDLE, CONVERT, SHIFT, DONE.
- IDLE:
  - start=1 at edge T latches the inputs and enters CONVERT; busy=1 from T+1.
  - If the clamped digit_count=0, go to DONE instead; overflow=0.
  - next_led is ignored in IDLE.
- CONVERT: extracts one digit per cycle, LSD first, over D=digit_count cycles (T+1..T+D).
  - Each cycle: digit = v % radix; v = v / radix. v starts as data.
  - Digit i (i≥1) is blank (code 0x00) when blank_lz=1 and v==0 before its extraction. Digit 0 is never blanked.
  - After D digits, overflow = (v != 0).
  - If overflow=1, every digit code is replaced by 0x40 (minus). dp bits still apply.
  - next_led is ignored in CONVERT.
- Segment code: bit0=a … bit6=g, bit7=dp=dp_mask[i], active-high.
  - Decimal digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Hex digits A-F: 77 7C 39 5E 79 71.
- SHIFT: entered at T+D+1 with led_valid=1.
  - led_data = bit b of digit d, starting at d=0, b=0 (bit0 first, digit 0 first). led_data is registered-stable between strobes.
  - Each cycle with next_led=1 advances b, then d. Total D*8 bits.
  - The strobe that consumes the last bit moves the block to DONE; led_valid=0 from the next cycle.
- DONE: one cycle; done=1, busy=0 from the following cycle, return to IDLE.
  - overflow holds until the next accepted start, where it clears.
- start while busy is ignored, with no effect on the latched data.
- next_led held high for k cycles advances k bits.

Test Plan:
- data=1, digit_count=2, dec, blank_lz=0, dp_mask=0; 16 strobes:
  - led_data sequence 0,1,1,0,0,0,0,0 then 1,1,1,1,1,1,0,0.
  - done pulses once; overflow=0.
- Same with blank_lz=1: second byte is all zeros; first byte is unchanged.
- data=16'hBEEF, digit_count=4, hex: bytes streamed 0x71,0x79,0x79,0x7C (LSB first each); busy high for exactly 4+32 cycles of strobing plus DONE.
- data=678, digit_count=2, dec: overflow=1; bytes 0x40,0x40. Then data=25, dp_mask=2'b10: bytes 0x6D,0xDB; overflow clears.
- digit_count=7 with MAX_DIGITS=5: clamped to 5 bytes (40 strobes).
- digit_count=0: done two cycles after start, led_valid never set.
- start pulsed during SHIFT with different data: ignored, stream unchanged.
- rst asserted after 5 strobes: all outputs 0 next cycle, no done.
- A fresh start then produces a full correct frame.

Source files
------------

// File: rtl/display_serializer_if.sv
// Bundles the frame request and serial LED stream signals of display_serializer.
// The master side (controller or bench) drives the requests and the strobes.
// The slave side (the serializer) drives the LED stream and the status flags.
interface display_serializer_if #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
);
  logic                  start;
  logic [DATA_W-1:0]     data;
  logic [CNT_W-1:0]      digit_count;
  logic                  hex_mode;
  logic                  blank_lz;
  logic [MAX_DIGITS-1:0] dp_mask;
  logic                  next_led;
  logic                  led_data;
  logic                  led_valid;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, data, digit_count, hex_mode, blank_lz, dp_mask, next_led,
    input  led_data, led_valid, busy, done, overflow
  );

  modport slave (
    input  start, data, digit_count, hex_mode, blank_lz, dp_mask, next_led,
    output led_data, led_valid, busy, done, overflow
  );
endinterface

// File: rtl/display_serializer.sv
// display_serializer: turns a binary value into up to MAX_DIGITS seven-segment
// bytes (segments a..g in bits 0..6, decimal point in bit 7). It extracts one
// digit per cycle, least significant digit first. It then streams the frame
// one bit per next_led strobe, bit 0 of digit 0 first.
module display_serializer #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  display_serializer_if.slave   bus
);

  localparam int FRAME_W = MAX_DIGITS * 8;
  localparam int BITS_W  = CNT_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic [DATA_W-1:0]     r_value;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_digIdx;
  logic                  r_hexMode;
  logic                  r_blankLz;
  logic [MAX_DIGITS-1:0] r_dpMask;
  logic [FRAME_W-1:0]    r_frame;
  logic [BITS_W-1:0]     r_bitsLeft;
  logic                  r_ledData;
  logic                  r_ledValid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;

  logic [CNT_W-1:0]      w_countClamped;
  logic [DATA_W-1:0]     w_quot;
  logic [3:0]            w_digit;
  logic [6:0]            w_seg;
  logic                  w_isBlank;
  logic                  w_lastDigit;
  logic                  w_overflowNow;
  logic [FRAME_W-1:0]    w_frameWrite;
  logic [FRAME_W-1:0]    w_minusFrame;
  logic [FRAME_W-1:0]    w_frameNext;

  // Seven-segment pattern for one digit value, active-high, a in bit 0.
  function automatic logic [6:0] segOf(input logic [3:0] digit);
    case (digit)
      4'h0:    segOf = 7'h3F;
      4'h1:    segOf = 7'h06;
      4'h2:    segOf = 7'h5B;
      4'h3:    segOf = 7'h4F;
      4'h4:    segOf = 7'h66;
      4'h5:    segOf = 7'h6D;
      4'h6:    segOf = 7'h7D;
      4'h7:    segOf = 7'h07;
      4'h8:    segOf = 7'h7F;
      4'h9:    segOf = 7'h6F;
      4'hA:    segOf = 7'h77;
      4'hB:    segOf = 7'h7C;
      4'hC:    segOf = 7'h39;
      4'hD:    segOf = 7'h5E;
      4'hE:    segOf = 7'h79;
      default: segOf = 7'h71;
    endcase
  endfunction

  assign w_countClamped = (bus.digit_count > CNT_W'(MAX_DIGITS)) ?
                          CNT_W'(MAX_DIGITS) : bus.digit_count;

  // Digit extraction: the remainder becomes the current digit, and the
  // quotient is the value left over for the next digit. Hex needs only a
  // shift; decimal uses a constant divide by ten.
  always_comb begin
    w_quot  = '0;
    w_digit = '0;
    if (r_hexMode) begin
      w_quot  = r_value >> 4;
      w_digit = r_value[3:0];
    end else begin
      w_quot  = r_value / DATA_W'(10);
      w_digit = 4'(r_value % DATA_W'(10));
    end
  end

  // Blanking applies to every digit above digit 0 once the value left to
  // convert is exhausted. A blanked digit still shows its decimal point.
  // The last digit index marks the cycle that settles overflow.
  always_comb begin
    w_isBlank     = r_blankLz && (r_digIdx != '0) && (r_value == '0);
    w_seg         = w_isBlank ? 7'h00 : segOf(w_digit);
    w_lastDigit   = (r_digIdx == (r_count - CNT_W'(1)));
    w_overflowNow = (w_quot != '0);
  end

  // Candidate frame contents: the frame with the current digit byte written
  // in, and the all-minus frame used when the value does not fit. Bytes
  // beyond the requested digit count stay zero.
  always_comb begin
    w_frameWrite = r_frame;
    w_minusFrame = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (CNT_W'(i) == r_digIdx) begin
        w_frameWrite[i*8 +: 8] = {r_dpMask[i], w_seg};
      end
      if (CNT_W'(i) < r_count) begin
        w_minusFrame[i*8 +: 8] = {r_dpMask[i], 7'h40};
      end
    end
  end

  // Next frame buffer. It is cleared on an accepted start and filled during
  // conversion; the last digit may swap in the minus frame. Each strobe in
  // SHIFT moves the next bit down to bit 0.
  always_comb begin
    w_frameNext = r_frame;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_frameNext = '0;
        end
      end
      ST_CONVERT: begin
        if (w_lastDigit && w_overflowNow) begin
          w_frameNext = w_minusFrame;
        end else begin
          w_frameNext = w_frameWrite;
        end
      end
      ST_SHIFT: begin
        if (bus.next_led) begin
          w_frameNext = r_frame >> 1;
        end
      end
      default: begin
        w_frameNext = r_frame;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. A zero digit count skips straight to DONE. The strobe
  // that consumes the final bit ends the frame.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_stateNext = (w_countClamped == '0) ? ST_DONE : ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (w_lastDigit) begin
          w_stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.next_led && (r_bitsLeft == BITS_W'(1))) begin
          w_stateNext = ST_DONE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. Inputs are latched only on a start
  // accepted in IDLE, so a start during a frame leaves it untouched. Overflow
  // stays visible until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value    <= '0;
      r_count    <= '0;
      r_digIdx   <= '0;
      r_hexMode  <= 1'b0;
      r_blankLz  <= 1'b0;
      r_dpMask   <= '0;
      r_frame    <= '0;
      r_bitsLeft <= '0;
      r_ledData  <= 1'b0;
      r_ledValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_frame    <= w_frameNext;
      r_ledData  <= (w_stateNext == ST_SHIFT) && w_frameNext[0];
      r_ledValid <= (w_stateNext == ST_SHIFT);
      r_busy     <= (w_stateNext != ST_IDLE);
      r_done     <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_value    <= bus.data;
            r_count    <= w_countClamped;
            r_hexMode  <= bus.hex_mode;
            r_blankLz  <= bus.blank_lz;
            r_dpMask   <= bus.dp_mask;
            r_digIdx   <= '0;
            r_overflow <= 1'b0;
          end
        end
        ST_CONVERT: begin
          r_value  <= w_quot;
          r_digIdx <= r_digIdx + CNT_W'(1);
          if (w_lastDigit) begin
            r_overflow <= w_overflowNow;
            r_bitsLeft <= {r_count, 3'b000};
          end
        end
        ST_SHIFT: begin
          if (bus.next_led) begin
            r_bitsLeft <= r_bitsLeft - BITS_W'(1);
          end
        end
        default: begin
          r_bitsLeft <= r_bitsLeft;
        end
      endcase
    end
  end

  assign bus.led_data  = r_ledData;
  assign bus.led_valid = r_ledValid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_display_serializer.sv
// Directed testbench for display_serializer: each frame is compared against
// hand-computed segment bytes, digit latency, done/busy timing and overflow.
module tb_display_serializer;

  logic clk;
  logic rst;
  int   totalChecks;
  int   badChecks;
  int   busyCycles;
  int   doneCount;
  int   validCount;
  logic [63:0] bits;
  int   lat;
  int   gaps;

  display_serializer_if #(.DATA_W(16), .MAX_DIGITS(5)) bus ();

  display_serializer #(.DATA_W(16), .MAX_DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts busy, done and led_valid cycles, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.busy)      busyCycles++;
    if (bus.done)      doneCount++;
    if (bus.led_valid) validCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues a one-cycle start with the given frame settings; returns one
  // cycle after the accepting edge.
  task automatic applyStimulus(input logic [15:0] d, input logic [2:0] cnt,
                               input logic hx, input logic blz,
                               input logic [4:0] dp);
    bus.data        = d;
    bus.digit_count = cnt;
    bus.hex_mode    = hx;
    bus.blank_lz    = blz;
    bus.dp_mask     = dp;
    bus.start       = 1'b1;
    busyCycles      = 0;
    doneCount       = 0;
    validCount      = 0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for led_valid, then strobes every cycle collecting
  // nBits. A different start is injected on strobe glitchAt (if >= 0).
  task automatic runFrame(input int nBits, input int glitchAt,
                          output logic [63:0] got, output int latency,
                          output int validGaps);
    latency   = 0;
    got       = '0;
    validGaps = 0;
    while (!bus.led_valid && latency < 200) begin
      @(negedge clk);
      latency++;
    end
    for (int i = 0; i < nBits; i++) begin
      got[i] = bus.led_data;
      if (!bus.led_valid) validGaps++;
      bus.next_led = 1'b1;
      if (i == glitchAt) begin
        bus.start       = 1'b1;
        bus.data        = 16'hFFFF;
        bus.hex_mode    = 1'b1;
        bus.digit_count = 3'd1;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.next_led = 1'b0;
  endtask

  initial begin
    totalChecks     = 0;
    badChecks       = 0;
    busyCycles      = 0;
    doneCount       = 0;
    validCount      = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.data        = '0;
    bus.digit_count = '0;
    bus.hex_mode    = 1'b0;
    bus.blank_lz    = 1'b0;
    bus.dp_mask     = '0;
    bus.next_led    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_led_data", 64'(bus.led_data), 64'd0);
    checkOutput("rst_led_valid", 64'(bus.led_valid), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_overflow", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // data=1, two decimal digits: 0x06 then 0x3F
    applyStimulus(16'd1, 3'd2, 1'b0, 1'b0, 5'b00000);
    runFrame(16, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("one_latency", 64'(lat), 64'd2);
    checkOutput("one_bits", bits, 64'h3F06);
    checkOutput("one_valid_gaps", 64'(gaps), 64'd0);
    checkOutput("one_done", 64'(doneCount), 64'd1);
    checkOutput("one_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("one_busy", 64'(busyCycles), 64'd19);
    checkOutput("one_valid_cnt", 64'(validCount), 64'd16);

    // Same with leading-zero blanking: upper byte blank
    applyStimulus(16'd1, 3'd2, 1'b0, 1'b1, 5'b00000);
    runFrame(16, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("blank_bits", bits, 64'h0006);
    checkOutput("blank_done", 64'(doneCount), 64'd1);

    // Hex BEEF: F,E,E,B -> 71,79,79,7C
    applyStimulus(16'hBEEF, 3'd4, 1'b1, 1'b0, 5'b00000);
    runFrame(32, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("hex_latency", 64'(lat), 64'd4);
    checkOutput("hex_bits", bits, 64'h7C797971);
    checkOutput("hex_busy", 64'(busyCycles), 64'd37);
    checkOutput("hex_done", 64'(doneCount), 64'd1);

    // 678 in two decimal digits overflows: minus signs
    applyStimulus(16'd678, 3'd2, 1'b0, 1'b0, 5'b00000);
    runFrame(16, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("ovf_bits", bits, 64'h4040);
    checkOutput("ovf_flag", 64'(bus.overflow), 64'd1);

    // 25 with dp on digit 1: overflow clears on the accepted start
    applyStimulus(16'd25, 3'd2, 1'b0, 1'b0, 5'b00010);
    checkOutput("ovf_clear_at_start", 64'(bus.overflow), 64'd0);
    runFrame(16, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("dp_bits", bits, 64'hDB6D);
    checkOutput("dp_overflow", 64'(bus.overflow), 64'd0);

    // digit_count=7 clamps to 5 digits of 54321
    applyStimulus(16'd54321, 3'd7, 1'b0, 1'b0, 5'b00000);
    runFrame(40, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("clamp_latency", 64'(lat), 64'd5);
    checkOutput("clamp_bits", bits, 64'h6D664F5B06);
    checkOutput("clamp_valid_cnt", 64'(validCount), 64'd40);
    checkOutput("clamp_done", 64'(doneCount), 64'd1);

    // digit_count=0: done two cycles after start, no stream
    applyStimulus(16'd1234, 3'd0, 1'b0, 1'b0, 5'b00000);
    checkOutput("zero_done_early", 64'(bus.done), 64'd0);
    @(negedge clk);
    checkOutput("zero_done", 64'(bus.done), 64'd1);
    checkOutput("zero_busy_low", 64'(bus.busy), 64'd0);
    repeat (4) @(negedge clk);
    checkOutput("zero_valid_cnt", 64'(validCount), 64'd0);
    checkOutput("zero_busy_cnt", 64'(busyCycles), 64'd1);
    checkOutput("zero_done_cnt", 64'(doneCount), 64'd1);

    // start during SHIFT is ignored: 1234 -> 66,4F,5B,06
    applyStimulus(16'd1234, 3'd4, 1'b0, 1'b0, 5'b00000);
    runFrame(32, 10, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("ignore_bits", bits, 64'h065B4F66);
    checkOutput("ignore_done", 64'(doneCount), 64'd1);
    checkOutput("ignore_overflow", 64'(bus.overflow), 64'd0);

    // Reset after 5 strobes of an overflowing frame
    applyStimulus(16'd678, 3'd2, 1'b0, 1'b0, 5'b00000);
    runFrame(5, -1, bits, lat, gaps);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_led_data", 64'(bus.led_data), 64'd0);
    checkOutput("mid_rst_valid", 64'(bus.led_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_overflow", 64'(bus.overflow), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("mid_rst_no_done", 64'(doneCount), 64'd0);

    // Fresh frame after reset: hex 9 with dp on digit 0 -> EF, 3F
    applyStimulus(16'h0009, 3'd2, 1'b1, 1'b0, 5'b00001);
    runFrame(16, -1, bits, lat, gaps);
    repeat (4) @(negedge clk);
    checkOutput("fresh_latency", 64'(lat), 64'd2);
    checkOutput("fresh_bits", bits, 64'h3FEF);
    checkOutput("fresh_done", 64'(doneCount), 64'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
